csa_final_adder: RTL

Multi-cycle carry-propagate adder that collapses the redundant sum/carry vector pair leaving the last carry-save stage of the Wallace tree into one binary product word. It sits directly downstream of the final carry-save stage. It accepts one (sum, carry) pair per transaction over a valid/ready handshake. It resolves carries `chunk` bits per cycle, trading latency for a short critical path, and presents the result over a second valid/ready handshake.

---
 rtl/csa_final_adder_if.sv | 26 ++
 rtl/csa_final_adder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/csa_final_adder_if.sv
// Handshake bundle between the last carry-save stage, the final adder and
// the consumer of the binary product word.
interface csa_final_adder_if #(
    parameter int bits = 63
);
    logic            in_valid;
    logic            in_ready;
    logic [bits:0]   s_in;
    logic [bits:0]   c_in;
    logic            out_valid;
    logic            out_ready;
    logic [bits:0]   p_out;
    logic            cout;

    // Upstream/downstream view: drives operands and out_ready, sees results.
    modport master (
        output in_valid, s_in, c_in, out_ready,
        input  in_ready, out_valid, p_out, cout
    );

    // Adder view.
    modport slave (
        input  in_valid, s_in, c_in, out_ready,
        output in_ready, out_valid, p_out, cout
    );
endinterface

// File: rtl/csa_final_adder.sv
// Multi-cycle carry-propagate adder collapsing a carry-save (sum, carry)
// pair into one binary word, resolving `chunk` bits per cycle.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for an operand pair; in_ready high
//   ST_ADD  | adding chunk k of A + B with the running carry, LSB first
//   ST_DONE | result held on p_out/cout; out_valid high until out_ready
//
// `chunk` must divide `bits+1`. The carry vector is unshifted on input
// (bit i weighs 2^(i+1)), so B is c_in shifted left by one; the bit that
// falls off the top is kept aside and folded into cout at the end.
module csa_final_adder #(
    parameter int bits  = 63,
    parameter int chunk = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    csa_final_adder_if.slave   bus
);
    localparam int W      = bits + 1;
    localparam int NCHUNK = W / chunk;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cmsb_q, cmsb_d;
    logic [W-1:0]    p_q, p_d;
    logic            cout_q, cout_d;

    logic [chunk-1:0] a_sl;
    logic [chunk-1:0] b_sl;
    logic [chunk:0]   csum;

    // Current chunk slice and its sum with the running carry.
    always_comb begin
        a_sl = a_q[int'(k_q)*chunk +: chunk];
        b_sl = b_q[int'(k_q)*chunk +: chunk];
        csum = {1'b0, a_sl} + {1'b0, b_sl} + {{chunk{1'b0}}, carry_q};
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cmsb_q  <= 1'b0;
            p_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmsb_q  <= cmsb_d;
            p_q     <= p_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath update; everything holds unless the state acts.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        cmsb_d  = cmsb_q;
        p_d     = p_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.s_in;
                    b_d     = W'({bus.c_in, 1'b0});
                    cmsb_d  = bus.c_in[bits];
                    k_d     = '0;
                    carry_d = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                p_d[int'(k_q)*chunk +: chunk] = csum[chunk-1:0];
                carry_d = csum[chunk];
                if (k_q == KW'(NCHUNK - 1)) begin
                    // Sum bit bits+1: only the dropped carry MSB and the final
                    // carry can land there, and never both with a further carry.
                    cout_d  = cmsb_q ^ csum[chunk];
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decode from the state register only.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.p_out     = p_q;
        bus.cout      = cout_q;
    end
endmodule
